// File: rtl/ram_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl_pkg
// Purpose  : Shared types and constants for the RAM burst sequencer
// Revision : 1.0 - initial release
// ============================================================================
package ram_burst_ctrl_pkg;

  // Defaults shared with the 32x32 single-port RAM
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 6;

  // Burst direction as carried on the dir command input
  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl_if
// Purpose  : Command, stream and RAM-side signals of the burst sequencer.
//            master = surrounding system, slave = the sequencer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_burst_ctrl_if
  import ram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  // command
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  // write stream
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  // read stream
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  // RAM side
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] S_addr;
  logic [DATA_W-1:0] S_din;
  logic [DATA_W-1:0] S_dout;

  modport master (
    output start, dir, base_addr, len, s_valid, s_data, m_ready, S_dout,
    input  busy, done, s_ready, m_valid, m_data, cen, wen, S_addr, S_din
  );

  modport slave (
    input  start, dir, base_addr, len, s_valid, s_data, m_ready, S_dout,
    output busy, done, s_ready, m_valid, m_data, cen, wen, S_addr, S_din
  );

endinterface
`default_nettype wire

// File: rtl/ram_burst_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_fifo2
// Purpose  : 2-entry synchronous FIFO holding RAM read data until the
//            read-stream consumer accepts it
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; push and pop may coincide
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // FIFO state registers; reset clears contents so head reads as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl
// Purpose  : Burst sequencer in front of the single-port RAM. Write bursts
//            store a valid/ready stream at consecutive addresses; read
//            bursts stream consecutive RAM words out with back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_burst_ctrl_if.slave  bus
);

  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;     // words still to accept (write) or pop (read)
  logic [LEN_W-1:0]  iss_q, iss_d;     // reads still to issue
  logic              inflight_q, inflight_d;

  logic [LEN_W-1:0]  len_eff;
  logic              ram_cen, ram_wen;
  logic              fifo_full, fifo_empty, pop;
  logic [DATA_W-1:0] fifo_head;
  logic [1:0]        occ;
  logic [2:0]        slots_used;

  assign len_eff = (bus.len > DEPTH) ? DEPTH : bus.len;

  // Read data lands on S_dout the cycle after an issued read; capture it then
  ram_burst_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (bus.S_dout),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per clock under continuous m_ready.
  assign slots_used = {2'b00, inflight_q} + {1'b0, occ} - {2'b00, pop};

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_FINISH);
  assign bus.s_ready = (state_q == ST_WRITE);
  assign bus.m_valid = (state_q == ST_READ) && !fifo_empty;
  assign bus.m_data  = fifo_head;
  assign pop         = bus.m_valid && bus.m_ready;
  assign bus.cen     = ram_cen;
  assign bus.wen     = ram_wen;
  assign bus.S_addr  = ram_cen ? cur_addr_q : '0;
  assign bus.S_din   = ram_wen ? bus.s_data : '0;

  // Next-state, RAM strobes and burst bookkeeping
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    iss_d      = iss_q;
    inflight_d = 1'b0;
    ram_cen    = 1'b0;
    ram_wen    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_eff == '0) begin
            state_d = ST_FINISH;
          end else begin
            cur_addr_d = bus.base_addr;
            rem_d      = len_eff;
            iss_d      = len_eff;
            state_d    = (bus.dir == DIR_WRITE) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (bus.s_valid) begin
          ram_cen    = 1'b1;
          ram_wen    = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_READ: begin
        if ((iss_q != '0) && (slots_used < 3'd2)) begin
          ram_cen    = 1'b1;
          inflight_d = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          iss_d      = iss_q - LEN_W'(1);
        end
        if (pop) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any burst without a done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      iss_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_ctrl
// Purpose  : Self-checking bench for ram_burst_ctrl with a RAM model and a
//            burst-level scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_ctrl_if bus ();

  ram_burst_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural 32x32 single-port RAM, read data one clock after access
  logic [31:0] ram_mem [32];
  always @(posedge clk) begin
    if (bus.cen) begin
      if (bus.wen) ram_mem[bus.S_addr] <= bus.S_din;
      else         bus.S_dout <= ram_mem[bus.S_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- burst-level model ----------------
  localparam int P_IDLE = 0, P_WR = 1, P_RD = 2, P_FIN = 3;
  int          ph = P_IDLE;
  int          mbase, mlen, k, iss;
  logic        hold = 1'b0;
  logic [31:0] hold_data;
  logic [31:0] shadow [32];
  logic [31:0] rd_q [$];
  int          wa_q [$];

  always @(negedge clk) begin
    if (!reset_n) begin
      ph   = P_IDLE;
      hold = 1'b0;
    end else begin
      case (ph)
        P_IDLE: begin
          chk("idle_busy", bus.busy, 0);
          chk("idle_done", bus.done, 0);
          chk("idle_cen", bus.cen, 0);
          chk("idle_s_ready", bus.s_ready, 0);
          chk("idle_m_valid", bus.m_valid, 0);
          if (bus.start) begin
            mlen = (bus.len > 6'd32) ? 32 : int'(bus.len);
            if (mlen == 0) ph = P_FIN;
            else begin
              ph    = bus.dir ? P_WR : P_RD;
              mbase = int'(bus.base_addr);
              k     = 0;
              iss   = 0;
            end
          end
        end
        P_WR: begin
          chk("wr_busy", bus.busy, 1);
          chk("wr_done", bus.done, 0);
          chk("wr_s_ready", bus.s_ready, 1);
          chk("wr_m_valid", bus.m_valid, 0);
          chk("wr_cen", bus.cen, bus.s_valid);
          chk("wr_wen", bus.wen, bus.s_valid);
          if (bus.s_valid) begin
            chk("wr_addr", bus.S_addr, (mbase + k) % 32);
            chk("wr_din", bus.S_din, bus.s_data);
            shadow[(mbase + k) % 32] = bus.s_data;
            wa_q.push_back(int'(bus.S_addr));
            k++;
            if (k == mlen) ph = P_FIN;
          end
        end
        P_RD: begin
          automatic logic popv = bus.m_valid && bus.m_ready;
          chk("rd_busy", bus.busy, 1);
          chk("rd_done", bus.done, 0);
          chk("rd_s_ready", bus.s_ready, 0);
          chk("rd_wen", bus.wen, 0);
          if (bus.cen) begin
            chk("rd_addr", bus.S_addr, (mbase + iss) % 32);
            iss++;
          end
          chk("rd_issue_bound", iss <= mlen, 1);
          chk("rd_outstanding", (iss - k - (popv ? 1 : 0)) <= 2, 1);
          if (hold) begin
            chk("rd_hold_valid", bus.m_valid, 1);
            chk("rd_hold_data", bus.m_data, hold_data);
          end
          if (bus.m_valid) chk("rd_data", bus.m_data, shadow[(mbase + k) % 32]);
          hold      = bus.m_valid && !bus.m_ready;
          hold_data = bus.m_data;
          if (popv) begin
            rd_q.push_back(bus.m_data);
            k++;
            if (k == mlen) ph = P_FIN;
          end
        end
        default: begin
          chk("fin_busy", bus.busy, 1);
          chk("fin_done", bus.done, 1);
          chk("fin_cen", bus.cen, 0);
          chk("fin_s_ready", bus.s_ready, 0);
          chk("fin_m_valid", bus.m_valid, 0);
          ph = P_IDLE;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  // Entered and left at posedge+1; lat = cycle index (1 = first after accept) of done
  task automatic run_cmd(input logic d, input int base, input int n, output int lat);
    bus.start     = 1'b1;
    bus.dir       = d;
    bus.base_addr = 5'(base);
    bus.len       = 6'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) chk("done_timeout", bus.done, 1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [31:0] w [$], input int stall_at);
    int   i = 0;
    int   guard = 0;
    int   stalls = 0;
    logic acc;
    while (i < w.size() && guard < 400) begin
      if (i == stall_at && stalls < 3) begin
        bus.s_valid = 1'b0;
        stalls++;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = w[i];
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic sink(input int n, input logic [3:0] pat);
    for (int c = 0; c < n; c++) begin
      bus.m_ready = pat[c % 4];
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] e [$]);
    chk({nm, "_count"}, rd_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < rd_q.size()) chk(nm, rd_q[i], e[i]);
  endtask

  task automatic chk_wa(input string nm, input int e [$]);
    chk({nm, "_count"}, wa_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < wa_q.size()) chk(nm, wa_q[i], e[i]);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_cen"}, bus.cen, 0);
    chk({nm, "_wen"}, bus.wen, 0);
    chk({nm, "_s_ready"}, bus.s_ready, 0);
    chk({nm, "_m_valid"}, bus.m_valid, 0);
    chk({nm, "_S_addr"}, bus.S_addr, 0);
    chk({nm, "_S_din"}, bus.S_din, 0);
    chk({nm, "_m_data"}, bus.m_data, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          lat;
    logic [31:0] wq [$];
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

    @(posedge clk); @(posedge clk); #1;
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // write 0xA..0xD at 0..3, then read back at full rate
    wq = '{32'hA, 32'hB, 32'hC, 32'hD};
    wa_q.delete();
    fork
      run_cmd(1'b1, 0, 4, lat);
      feed(wq, 99);
    join
    chk("t1_wr_latency", lat, 5);
    chk_wa("t1_wr_addr", '{0, 1, 2, 3});
    rd_q.delete();
    bus.m_ready = 1'b1;
    run_cmd(1'b0, 0, 4, lat);
    chk("t1_rd_latency", lat, 7);
    chk_rd("t1_rd_word", '{32'hA, 32'hB, 32'hC, 32'hD});

    // read with m_ready pattern 1,0,0,1
    rd_q.delete();
    fork
      run_cmd(1'b0, 0, 4, lat);
      sink(40, 4'b1001);
    join
    chk_rd("t2_bp_word", '{32'hA, 32'hB, 32'hC, 32'hD});

    // wrap-around write with a 3-cycle stall, then read back
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    wa_q.delete();
    fork
      run_cmd(1'b1, 30, 4, lat);
      feed(wq, 2);
    join
    chk("t3_wr_latency", lat, 8);
    chk_wa("t3_wr_addr", '{30, 31, 0, 1});
    rd_q.delete();
    bus.m_ready = 1'b1;
    run_cmd(1'b0, 30, 4, lat);
    chk("t3_rd_latency", lat, 7);
    chk_rd("t3_rd_word", '{32'h11, 32'h22, 32'h33, 32'h44});

    // zero length
    wa_q.delete();
    run_cmd(1'b1, 5, 0, lat);
    chk("t4_zero_latency", lat, 1);
    chk("t4_zero_no_write", wa_q.size(), 0);

    // start pulsed while busy is ignored
    wq = '{32'h1, 32'h2, 32'h3};
    wa_q.delete();
    fork
      run_cmd(1'b1, 8, 3, lat);
      feed(wq, 99);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 5'd20; bus.len = 6'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    join
    chk("t5_latency", lat, 4);
    chk_wa("t5_wr_addr", '{8, 9, 10});

    // len > 32 clamps to a full 32-word burst
    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back(32'(i * 3 + 1));
    fork
      run_cmd(1'b1, 0, 40, lat);
      feed(wq, 99);
    join
    chk("t6_clamp_latency", lat, 33);

    // async reset in the middle of a len=8 read
    bus.m_ready = 1'b1;
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 5'd0; bus.len = 6'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd_q.delete();
    run_cmd(1'b0, 8, 3, lat);
    chk("t7_rd_latency", lat, 6);
    chk_rd("t7_rd_word", '{32'd25, 32'd28, 32'd31});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
